encode_using_key: RTL and testbench
===================================

# encode_using_key

RC4 stream-cipher encoder that pairs with `decode_using_key`. It reads an `MSG_LEN`-byte plaintext from an external synchronous RAM and runs S-box init, KSA and PRGA with a 24-bit secret key. It writes the ciphertext to an external RAM. It sits beside the decoder under the board top and produces the encrypted messages the decoder consumes. Because RC4 is symmetric, feeding ciphertext back in returns the plaintext.

## Interface
Parameters:
- `MSG_LEN`, default 32: message length in bytes, range 1..256.
- `ADDR_W`, default 5: width of message address, equal to $clog2(MSG_LEN) with a minimum of 1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: level request; accepted only in IDLE.
- `secret_key` in 24: key bytes k0=[23:16], k1=[15:8], k2=[7:0]; latched on acceptance.
- `pt_addr` out ADDR_W: plaintext RAM read address.
- `pt_rdata` in 8: plaintext read data, valid 1 cycle after `pt_addr`.
- `ct_addr` out ADDR_W: ciphertext write address.
- `ct_wdata` out 8: ciphertext byte.
- `ct_wren` out 1: ciphertext write strobe, 1-cycle pulse per byte.
- `busy` out 1: high from the cycle after acceptance until DONE.
- `done` out 1: high in DONE.

## Operation
- IDLE: if `start`=1, latch key, clear i/j/k, go to INIT.
- INIT: write S[i]=i for i=0..255, 1 cycle each; go to KSA at i=255.
- KSA, five states per i, with j starting at 0:
  - K_RI: address i.
  - K_CJ: si=q; j=j+si+key[i mod 3]; address j.
  - K_RJ: sj=q.
  - K_WI: write S[i]=sj.
  - K_WJ: write S[j]=si. If i=255, go to PRGA with i=j=k=0; otherwise i++ and return to K_RI.
- PRGA, seven states per byte k:
  - P_I: i=i+1; address i; `pt_addr`=k.
  - P_CJ: si=q; j=j+si; address j.
  - P_RJ: sj=q.
  - P_WI: write S[i]=sj.
  - P_WJ: write S[j]=si.
  - P_RF: address (si+sj).
  - P_XW: `ct_wdata`=q^`pt_rdata`; `ct_addr`=k; `ct_wren`=1. If k=MSG_LEN-1 go to DONE, otherwise k++ and return to P_I.
- DONE: `done`=1 and `busy`=0. Stay while `start`=1; go to IDLE when `start`=0, at which point `done` drops.
- Arithmetic: all i/j/index sums are 8-bit and wrap mod 256; k wraps never, since it stops at MSG_LEN-1.
- i==j swap: both writes carry the same value. This is correct and needs no special case.
- `pt_addr` is held stable from P_I through P_XW.
- `secret_key` and `start` changes during a run are ignored.

## Timing
- Reset, on any cycle including mid-run:
  - Next cycle: state=IDLE; `busy`, `done`, `ct_wren`, `ct_addr`, `ct_wdata` and `pt_addr` all 0; i, j, k cleared.
  - S contents are not cleared; INIT rewrites them.
- Acceptance cycle A: `busy`=1 from A+1.
- Phase lengths: INIT 256 cycles; KSA 1280 cycles; PRGA 7·MSG_LEN cycles.
- First `ct_wren` at A+1+256+1280+6. Successive writes are exactly 7 cycles apart, at `ct_addr` 0,1,…,MSG_LEN-1 in order.
- `done`=1 the cycle after the last write, i.e. A+1+1536+7·MSG_LEN. For MSG_LEN=32 that is 1761 cycles after A.
- S memory: read latency 1 cycle; no read and write in the same cycle.

## Structure
- Package `rc4_pkg`:
  - State enum.
  - `S_DEPTH`=256 and `KEY_BYTES`=3.
  - Function `key_byte(key, idx)` returning the key byte for idx mod 3.
  - Shared with `decode_using_key`.
- Sub-module `s_memory`: 256×8 single-port synchronous RAM with inputs `clk`, `address`, `data`, `wren` and output `q`, 1-cycle read. This is the same S-box store the decoder uses.
- FSM, datapath registers (i, j, k, si, sj, latched key) and address muxing live in `encode_using_key`.

## Test plan
1. Known vector, MSG_LEN=9: key 24'h4B6579 ("Key") with plaintext "Plaintext" must write BB F3 16 E8 D9 40 AF 0A D3 at addresses 0..8.
2. Round trip, MSG_LEN=32, key 24'h000249: encode 32 random bytes, then encode the ciphertext with the same key; the result must equal the original plaintext bit-exact.
3. Keystream, key 24'h3FFFFF: all-zero plaintext must produce ciphertext equal to the software RC4 keystream; bench model compared at every `ct_wren`.
4. Cycle accounting, MSG_LEN=32, `start` at cycle A:
   - `busy` rises at A+1.
   - Exactly 32 `ct_wren` pulses, 7 cycles apart, first at A+1543.
   - `done` at A+1761.
5. Reset mid-KSA: `reset_n`=0 for 1 cycle at A+600.
   - Next cycle: all outputs 0 and no `ct_wren`.
   - A restart with the same key yields ciphertext identical to scenario 2's first pass.
6. Start handling: `start` held high through completion, and `secret_key` changed at A+100.
   - `done` stays high with no restart or `ct_wren`.
   - Output matches the originally latched key.
   - Lowering `start` returns to IDLE; raising it again starts a fresh run.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions for encode_using_key and decode_using_key:
// FSM state type, S-box geometry and key-byte selection.
package rc4_pkg;

  localparam int S_DEPTH   = 256;
  localparam int KEY_BYTES = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_K_RI,
    ST_K_CJ,
    ST_K_RJ,
    ST_K_WI,
    ST_K_WJ,
    ST_P_I,
    ST_P_CJ,
    ST_P_RJ,
    ST_P_WI,
    ST_P_WJ,
    ST_P_RF,
    ST_P_XW,
    ST_DONE
  } rc4_state_e;

  // Key bytes are stored big-endian: k0 in the top byte.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx);
    logic [7:0] sel;
    sel = idx % 8'(KEY_BYTES);
    case (sel)
      8'd0:    key_byte = key[23:16];
      8'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/s_memory.sv
// 256x8 single-port synchronous RAM holding the RC4 S-box; registered read.
module s_memory (
  input  logic       clk,
  input  logic [7:0] address,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);

  logic [7:0] mem [256];

  // NOTE: the array has no reset; INIT rewrites every entry before use,
  // and leaving it unreset lets synthesis map it onto block RAM.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/encode_using_key.sv
// RC4 encoder: S-box init, KSA with a 24-bit key, then PRGA XOR over an
// MSG_LEN-byte message read from and written to external synchronous RAMs.
module encode_using_key
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [23:0]       secret_key,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [7:0]        pt_rdata,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [7:0]        ct_wdata,
  output logic              ct_wren,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  rc4_state_e        state;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [ADDR_W-1:0] k;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [23:0]       key_q;

  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_wren;
  logic [7:0] q;
  logic [7:0] j_sum;

  s_memory u_s_memory (
    .clk     (clk),
    .address (mem_addr),
    .data    (mem_data),
    .wren    (mem_wren),
    .q       (q)
  );

  // New j is needed as an address in the same cycle S[i] arrives on q.
  always_comb begin
    j_sum = j + q;
    if (state == ST_K_CJ) begin
      j_sum = j + q + key_byte(key_q, i);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    mem_addr = i;
    mem_data = sj;
    mem_wren = 1'b0;
    case (state)
      ST_INIT: begin
        mem_data = i;
        mem_wren = 1'b1;
      end
      ST_K_CJ, ST_P_CJ: mem_addr = j_sum;
      ST_K_WI, ST_P_WI: begin
        mem_addr = i;
        mem_data = sj;
        mem_wren = 1'b1;
      end
      ST_K_WJ, ST_P_WJ: begin
        mem_addr = j;
        mem_data = si;
        mem_wren = 1'b1;
      end
      ST_P_I:  mem_addr = i + 8'd1;
      ST_P_RF: mem_addr = si + sj;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      si    <= '0;
      sj    <= '0;
      key_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_q <= secret_key;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          i <= i + 8'd1;
          if (i == 8'd255) begin
            state <= ST_K_RI;
          end
        end
        ST_K_RI: state <= ST_K_CJ;
        ST_K_CJ: begin
          si    <= q;
          j     <= j_sum;
          state <= ST_K_RJ;
        end
        ST_K_RJ: begin
          sj    <= q;
          state <= ST_K_WI;
        end
        ST_K_WI: state <= ST_K_WJ;
        ST_K_WJ: begin
          if (i == 8'd255) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            state <= ST_P_I;
          end else begin
            i     <= i + 8'd1;
            state <= ST_K_RI;
          end
        end
        ST_P_I: begin
          i     <= i + 8'd1;
          state <= ST_P_CJ;
        end
        ST_P_CJ: begin
          si    <= q;
          j     <= j_sum;
          state <= ST_P_RJ;
        end
        ST_P_RJ: begin
          sj    <= q;
          state <= ST_P_WI;
        end
        ST_P_WI: state <= ST_P_WJ;
        ST_P_WJ: state <= ST_P_RF;
        ST_P_RF: state <= ST_P_XW;
        ST_P_XW: begin
          if (k == LAST_K) begin
            state <= ST_DONE;
          end else begin
            k     <= k + 1'b1;
            state <= ST_P_I;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // pt_addr is k for the whole byte, so pt_rdata is valid by P_XW.
  assign pt_addr  = k;
  assign ct_wren  = (state == ST_P_XW);
  assign ct_addr  = ct_wren ? k : '0;
  assign ct_wdata = ct_wren ? (q ^ pt_rdata) : 8'h00;
  assign busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_encode_using_key.sv
// Self-checking bench for encode_using_key against a software RC4 model.
module tb_encode_using_key;

  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [23:0]       secret_key;
  logic [ADDR_W-1:0] pt_addr;
  logic [7:0]        pt_rdata;
  logic [ADDR_W-1:0] ct_addr;
  logic [7:0]        ct_wdata;
  logic              ct_wren;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] pt_mem   [MSG_LEN];
  logic [7:0] ct_mem   [MSG_LEN];
  logic [7:0] exp_ct   [MSG_LEN];
  logic [7:0] saved_pt [MSG_LEN];
  logic [7:0] first_ct [MSG_LEN];

  int              wr_cyc  [$];
  logic [7:0]      wr_data [$];
  logic [ADDR_W-1:0] wr_addr [$];
  int busy_rise, done_rise, a_cyc;
  logic busy_q = 1'b0, done_q = 1'b0;

  encode_using_key #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .secret_key (secret_key),
    .pt_addr    (pt_addr),
    .pt_rdata   (pt_rdata),
    .ct_addr    (ct_addr),
    .ct_wdata   (ct_wdata),
    .ct_wren    (ct_wren),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) pt_rdata <= pt_mem[pt_addr];

  always @(negedge clk) begin
    if (ct_wren) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(ct_addr);
      wr_data.push_back(ct_wdata);
      ct_mem[ct_addr] = ct_wdata;
    end
    if (busy && !busy_q && busy_rise < 0) busy_rise = cyc;
    if (done && !done_q && done_rise < 0) done_rise = cyc;
    busy_q = busy;
    done_q = done;
  end

  // Textbook RC4 over the current pt_mem contents.
  task automatic model_encode(input logic [23:0] key);
    int s [256];
    int kb [3];
    int ii, jj, t;
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    for (int n = 0; n < 256; n++) s[n] = n;
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = (jj + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[jj]; s[jj] = t;
    end
    ii = 0;
    jj = 0;
    for (int n = 0; n < MSG_LEN; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + s[ii]) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      exp_ct[n] = pt_mem[n] ^ 8'(s[(s[ii] + s[jj]) % 256]);
    end
  endtask

  task automatic start_run(input logic [23:0] key);
    @(negedge clk);
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    for (int n = 0; n < MSG_LEN; n++) ct_mem[n] = 8'hxx;
    busy_rise  = -1;
    done_rise  = -1;
    secret_key = key;
    start      = 1'b1;
    a_cyc      = cyc;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic end_run();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    secret_key = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ct_wren, ct_addr, ct_wdata, pt_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b wren=%0b ct_addr=%0d wdata=%02h pt_addr=%0d, required all 0",
               busy, done, ct_wren, ct_addr, ct_wdata, pt_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_known_vector();
    logic [71:0] txt;
    logic [7:0] kv [9];
    txt = "Plaintext";
    kv = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = 8'($urandom);
    for (int n = 0; n < 9; n++) pt_mem[n] = txt[71-8*n -: 8];
    model_encode(24'h4B6579);
    start_run(24'h4B6579);
    wait_done("known_vector");
    end_run();
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (ct_mem[n] !== kv[n]) begin
        errors++;
        $display("FAIL known_vector[%0d]: got %02h, required %02h", n, ct_mem[n], kv[n]);
      end
    end
    for (int n = 9; n < MSG_LEN; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++;
        $display("FAIL known_vector_tail[%0d]: got %02h, required %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_round_trip();
    for (int n = 0; n < MSG_LEN; n++) begin
      pt_mem[n]   = 8'($urandom);
      saved_pt[n] = pt_mem[n];
    end
    model_encode(24'h000249);
    start_run(24'h000249);
    wait_done("round_trip_1");
    end_run();
    for (int n = 0; n < MSG_LEN; n++) begin
      first_ct[n] = exp_ct[n];
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++;
        $display("FAIL round_trip_ct[%0d]: got %02h, required %02h", n, ct_mem[n], exp_ct[n]);
      end
      pt_mem[n] = ct_mem[n];
    end
    start_run(24'h000249);
    wait_done("round_trip_2");
    end_run();
    for (int n = 0; n < MSG_LEN; n++) begin
      checks++;
      if (ct_mem[n] !== saved_pt[n]) begin
        errors++;
        $display("FAIL round_trip_pt[%0d]: got %02h, required %02h", n, ct_mem[n], saved_pt[n]);
      end
    end
  endtask

  task automatic test_keystream();
    for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = 8'h00;
    model_encode(24'h3FFFFF);
    start_run(24'h3FFFFF);
    wait_done("keystream");
    end_run();
    checks++;
    if (wr_data.size() != MSG_LEN) begin
      errors++;
      $display("FAIL keystream_count: got %0d writes, required %0d", wr_data.size(), MSG_LEN);
    end
    for (int n = 0; n < wr_data.size() && n < MSG_LEN; n++) begin
      checks++;
      if (wr_data[n] !== exp_ct[n] || wr_addr[n] !== ADDR_W'(n)) begin
        errors++;
        $display("FAIL keystream[%0d]: got addr %0d data %02h, required addr %0d data %02h",
                 n, wr_addr[n], wr_data[n], n, exp_ct[n]);
      end
    end
  endtask

  task automatic test_cycle_accounting();
    logic [23:0] key;
    key = 24'($urandom);
    for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = 8'($urandom);
    start_run(key);
    wait_done("cycles");
    end_run();
    checks++;
    if (busy_rise != a_cyc + 1) begin
      errors++;
      $display("FAIL busy_rise: got A+%0d, required A+1", busy_rise - a_cyc);
    end
    checks++;
    if (wr_cyc.size() != MSG_LEN) begin
      errors++;
      $display("FAIL wren_count: got %0d, required %0d", wr_cyc.size(), MSG_LEN);
    end
    for (int n = 0; n < wr_cyc.size() && n < MSG_LEN; n++) begin
      checks++;
      if (wr_cyc[n] != a_cyc + 1543 + 7 * n || wr_addr[n] !== ADDR_W'(n)) begin
        errors++;
        $display("FAIL wren_timing[%0d]: got A+%0d addr %0d, required A+%0d addr %0d",
                 n, wr_cyc[n] - a_cyc, wr_addr[n], 1543 + 7 * n, n);
      end
    end
    checks++;
    if (done_rise != a_cyc + 1761) begin
      errors++;
      $display("FAIL done_rise: got A+%0d, required A+1761", done_rise - a_cyc);
    end
  endtask

  task automatic test_reset_mid_ksa();
    for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = saved_pt[n];
    start_run(24'h000249);
    while (cyc < a_cyc + 600) @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({busy, done, ct_wren, ct_addr, ct_wdata, pt_addr} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%0b done=%0b wren=%0b ct_addr=%0d wdata=%02h pt_addr=%0d, required all 0",
               busy, done, ct_wren, ct_addr, ct_wdata, pt_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cyc.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got %0d writes busy=%0b, required 0 writes busy=0", wr_cyc.size(), busy);
    end
    start_run(24'h000249);
    wait_done("restart");
    end_run();
    for (int n = 0; n < MSG_LEN; n++) begin
      checks++;
      if (ct_mem[n] !== first_ct[n]) begin
        errors++;
        $display("FAIL restart_ct[%0d]: got %02h, required %02h", n, ct_mem[n], first_ct[n]);
      end
    end
  endtask

  task automatic test_start_handling();
    logic [23:0] key_a, key_b;
    int bad;
    key_a = 24'hA5C31E;
    key_b = 24'h1234F0;
    for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = 8'($urandom);
    model_encode(key_a);
    start_run(key_a);
    while (cyc < a_cyc + 100) @(negedge clk);
    secret_key = key_b;
    wait_done("held_start");
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (done !== 1'b1 || busy !== 1'b0 || ct_wren !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || wr_cyc.size() != MSG_LEN) begin
      errors++;
      $display("FAIL done_hold: got %0d bad cycles and %0d writes, required 0 and %0d", bad, wr_cyc.size(), MSG_LEN);
    end
    for (int n = 0; n < MSG_LEN; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++;
        $display("FAIL latched_key_ct[%0d]: got %02h, required %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: done=%0b busy=%0b, required 0 0", done, busy);
    end
    model_encode(key_b);
    start_run(key_b);
    wait_done("second_run");
    end_run();
    for (int n = 0; n < MSG_LEN; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++;
        $display("FAIL second_run_ct[%0d]: got %02h, required %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  initial begin
    for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = 8'h00;
    test_reset();
    test_known_vector();
    test_round_trip();
    test_keystream();
    test_cycle_accounting();
    test_reset_mid_ksa();
    test_start_handling();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
